// File: rtl/mem_line_fill.sv
// Initiator side of the wait-state memory port: single-word writes and
// 16-word aligned line-fill reads, streamed back to the cache client with an index.
module mem_line_fill #(
    parameter int unsigned DATA_SIZE  = 32,
    parameter int unsigned ADDR_BITS  = 16,
    parameter int unsigned LINE_WORDS = 16,
    parameter int unsigned GAP_CYCLES = 4,
    parameter int unsigned TIMEOUT    = 15
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 CReq,
    input  logic                 CWrite,
    input  logic [ADDR_BITS-1:0] CAddr,
    input  logic [DATA_SIZE-1:0] CWriteData,
    output logic                 CReady,
    output logic                 FillValid,
    output logic [3:0]           FillIndex,
    output logic [DATA_SIZE-1:0] FillData,
    output logic                 FillDone,
    output logic                 FillError,
    output logic                 MEnable,
    output logic                 MRead,
    output logic                 MWrite,
    output logic [ADDR_BITS-1:0] MAddress,
    output logic [DATA_SIZE-1:0] MWriteData,
    input  logic [DATA_SIZE-1:0] MReadData,
    input  logic                 MReady
);

    localparam int unsigned GapW = $clog2(GAP_CYCLES + 1);
    localparam int unsigned ToW  = $clog2(TIMEOUT + 1);

    localparam logic [3:0]           LastIdx  = 4'(LINE_WORDS - 1);
    localparam logic [ADDR_BITS-1:0] LineMask = ADDR_BITS'(LINE_WORDS * 4 - 1);
    localparam logic [ADDR_BITS-1:0] WordMask = ADDR_BITS'(3);
    localparam logic [GapW-1:0]      GapInit  = GapW'(GAP_CYCLES);
    localparam logic [ToW-1:0]       ToLast   = ToW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWaitLow,
        StWaitData,
        StBurst,
        StGap
    } state_e;

    state_e               state_q, state_d;
    logic [GapW-1:0]      gap_q, gap_d;
    logic [ToW-1:0]       tmo_q, tmo_d;
    logic [3:0]           widx_q, widx_d;

    logic                 m_enable_q, m_enable_d;
    logic                 m_read_q, m_read_d;
    logic                 m_write_q, m_write_d;
    logic [ADDR_BITS-1:0] m_addr_q, m_addr_d;
    logic [DATA_SIZE-1:0] m_wdata_q, m_wdata_d;

    logic                 fill_valid_q, fill_valid_d;
    logic [3:0]           fill_index_q, fill_index_d;
    logic [DATA_SIZE-1:0] fill_data_q, fill_data_d;
    logic                 fill_done_q, fill_done_d;
    logic                 fill_error_q, fill_error_d;
    logic                 c_ready;

    always_comb begin
        state_d      = state_q;
        gap_d        = gap_q;
        tmo_d        = tmo_q;
        widx_d       = widx_q;
        m_enable_d   = 1'b0;
        m_read_d     = 1'b0;
        m_write_d    = 1'b0;
        m_addr_d     = '0;
        m_wdata_d    = '0;
        fill_valid_d = 1'b0;
        fill_index_d = '0;
        fill_data_d  = '0;
        fill_done_d  = 1'b0;
        fill_error_d = 1'b0;
        c_ready      = 1'b0;

        unique case (state_q)
            StIdle: begin
                // MReady high in idle means the memory has finished any prior commit.
                c_ready = MReady;
                if (CReq && MReady) begin
                    m_enable_d = 1'b1;
                    m_read_d   = ~CWrite;
                    m_write_d  = CWrite;
                    m_addr_d   = CWrite ? (CAddr & ~WordMask) : (CAddr & ~LineMask);
                    m_wdata_d  = CWriteData;
                    state_d    = StIssue;
                end
            end
            StIssue: begin
                tmo_d = ToW'(1);
                if (m_write_q) begin
                    state_d = StGap;
                    gap_d   = GapInit;
                end else begin
                    state_d = StWaitLow;
                end
            end
            StWaitLow, StWaitData: begin
                if (state_q == StWaitData && MReady) begin
                    fill_valid_d = 1'b1;
                    fill_index_d = 4'd0;
                    fill_data_d  = MReadData;
                    widx_d       = 4'd1;
                    state_d      = StBurst;
                end else if (tmo_q == ToLast) begin
                    fill_error_d = 1'b1;
                    state_d      = StGap;
                    gap_d        = GapInit;
                end else begin
                    tmo_d = tmo_q + ToW'(1);
                    if (state_q == StWaitLow && !MReady) begin
                        state_d = StWaitData;
                    end
                end
            end
            StBurst: begin
                fill_valid_d = 1'b1;
                fill_index_d = widx_q;
                fill_data_d  = MReadData;
                if (widx_q == LastIdx) begin
                    fill_done_d = 1'b1;
                    widx_d      = 4'd0;
                    state_d     = StGap;
                    gap_d       = GapInit;
                end else begin
                    widx_d = widx_q + 4'd1;
                end
            end
            StGap: begin
                if (gap_q <= GapW'(1)) begin
                    state_d = StIdle;
                end else begin
                    gap_d = gap_q - GapW'(1);
                end
            end
            default: state_d = StGap;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= StGap;
            gap_q        <= GapInit;
            tmo_q        <= '0;
            widx_q       <= '0;
            m_enable_q   <= 1'b0;
            m_read_q     <= 1'b0;
            m_write_q    <= 1'b0;
            m_addr_q     <= '0;
            m_wdata_q    <= '0;
            fill_valid_q <= 1'b0;
            fill_index_q <= '0;
            fill_data_q  <= '0;
            fill_done_q  <= 1'b0;
            fill_error_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            gap_q        <= gap_d;
            tmo_q        <= tmo_d;
            widx_q       <= widx_d;
            m_enable_q   <= m_enable_d;
            m_read_q     <= m_read_d;
            m_write_q    <= m_write_d;
            m_addr_q     <= m_addr_d;
            m_wdata_q    <= m_wdata_d;
            fill_valid_q <= fill_valid_d;
            fill_index_q <= fill_index_d;
            fill_data_q  <= fill_data_d;
            fill_done_q  <= fill_done_d;
            fill_error_q <= fill_error_d;
        end
    end

    assign CReady     = c_ready;
    assign FillValid  = fill_valid_q;
    assign FillIndex  = fill_index_q;
    assign FillData   = fill_data_q;
    assign FillDone   = fill_done_q;
    assign FillError  = fill_error_q;
    assign MEnable    = m_enable_q;
    assign MRead      = m_read_q;
    assign MWrite     = m_write_q;
    assign MAddress   = m_addr_q;
    assign MWriteData = m_wdata_q;

endmodule

// File: tb/tb_mem_line_fill.sv
// Bench for mem_line_fill: wait-state memory model, word-array reference of memory
// contents, table vectors, random requests and hand-written reset/timeout/hold sequences.
module tb_mem_line_fill;

    localparam int GAP = 4;
    localparam int TMO = 15;
    localparam int LW  = 16;

    logic        clock;
    logic        reset;
    logic        CReq;
    logic        CWrite;
    logic [15:0] CAddr;
    logic [31:0] CWriteData;
    logic        CReady;
    logic        FillValid;
    logic [3:0]  FillIndex;
    logic [31:0] FillData;
    logic        FillDone;
    logic        FillError;
    logic        MEnable;
    logic        MRead;
    logic        MWrite;
    logic [15:0] MAddress;
    logic [31:0] MWriteData;
    logic [31:0] MReadData;
    logic        MReady;

    mem_line_fill #(
        .DATA_SIZE (32),
        .ADDR_BITS (16),
        .LINE_WORDS(LW),
        .GAP_CYCLES(GAP),
        .TIMEOUT   (TMO)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .CReq      (CReq),
        .CWrite    (CWrite),
        .CAddr     (CAddr),
        .CWriteData(CWriteData),
        .CReady    (CReady),
        .FillValid (FillValid),
        .FillIndex (FillIndex),
        .FillData  (FillData),
        .FillDone  (FillDone),
        .FillError (FillError),
        .MEnable   (MEnable),
        .MRead     (MRead),
        .MWrite    (MWrite),
        .MAddress  (MAddress),
        .MWriteData(MWriteData),
        .MReadData (MReadData),
        .MReady    (MReady)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    logic [31:0] mem     [0:16383];  // what the memory model holds
    logic [31:0] ref_mem [0:16383];  // what the client expects memory to hold
    int          mem_wait;
    bit          dead_mem;
    int          n_cmp;
    int          n_bad;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // Memory: drops MReady after a read, waits mem_wait negedges, then streams 16 words.
    initial begin : mem_model
        int          phase;
        int          cnt;
        int          widx;
        logic [13:0] base;
        phase     = 0;
        cnt       = 0;
        widx      = 0;
        base      = '0;
        MReady    = 1'b1;
        MReadData = '0;
        forever begin
            @(negedge clock);
            if (!reset) begin
                phase     = 0;
                MReady    = 1'b1;
                MReadData = '0;
            end else if (phase == 0) begin
                if (MEnable && MWrite) begin
                    mem[MAddress[15:2]] = MWriteData;
                end else if (MEnable && MRead && !dead_mem) begin
                    base   = MAddress[15:2];
                    cnt    = mem_wait;
                    MReady = 1'b0;
                    phase  = 1;
                end
            end else if (phase == 1) begin
                cnt--;
                if (cnt == 0) begin
                    MReady    = 1'b1;
                    MReadData = mem[base];
                    widx      = 1;
                    phase     = 2;
                end
            end else begin
                if (widx == LW) begin
                    MReadData = '0;
                    phase     = 0;
                end else begin
                    MReadData = mem[base + 14'(widx)];
                    widx++;
                end
            end
        end
    end

    // Present a request until accepted; returns sampling inside the ISSUE cycle.
    task automatic send_req(input logic wr, input logic [15:0] addr, input logic [31:0] wd);
        int n;
        CReq       = 1'b1;
        CWrite     = wr;
        CAddr      = addr;
        CWriteData = wd;
        n          = 0;
        @(negedge clock);
        #1;
        while (!CReady && n < 300) begin
            @(negedge clock);
            #1;
            n++;
        end
        check("accept_ready", 128'(CReady), 128'(1));
        @(posedge clock);
        #1;
        CReq       = 1'b0;
        CWrite     = 1'($urandom);
        CAddr      = 16'($urandom);
        CWriteData = $urandom;
        @(negedge clock);
        #1;
    endtask

    // Full transaction check against the reference memory and timing rules.
    task automatic run_req(input logic wr, input logic [15:0] addr, input logic [31:0] wd,
                           output logic [15:0] o_maddr, output logic [31:0] o_w0);
        logic [15:0] ea;
        logic [13:0] wa;
        int          nfill;
        int          nerr;
        int          ndone;
        int          fill0_cyc;
        int          err_cyc;
        int          rdy_cyc;
        bit          done_ok;
        ea        = wr ? 16'(addr - addr % 4) : 16'(addr - addr % (LW * 4));
        nfill     = 0;
        nerr      = 0;
        ndone     = 0;
        fill0_cyc = -1;
        err_cyc   = -1;
        rdy_cyc   = -1;
        done_ok   = 1'b1;
        o_w0      = '0;
        send_req(wr, addr, wd);
        o_maddr = MAddress;
        check("issue_cmd", 128'({MEnable, MRead, MWrite}), 128'({1'b1, ~wr, wr}));
        check("issue_addr", 128'(MAddress), 128'(ea));
        if (wr) begin
            check("issue_wdata", 128'(MWriteData), 128'(wd));
            ref_mem[ea[15:2]] = wd;
        end
        check("issue_cready", 128'(CReady), 128'(0));
        for (int cyc = 1; cyc < 400; cyc++) begin
            @(negedge clock);
            #1;
            if (cyc == 1) begin
                check("mbus_idle", 128'({MEnable, MRead, MWrite, MAddress, MWriteData}), 128'(0));
            end
            if (FillValid) begin
                wa = 14'(int'(ea[15:2]) + nfill);
                if (nfill == 0) begin
                    fill0_cyc = cyc;
                    o_w0      = FillData;
                end
                check("fill_word", 128'({FillIndex, FillData}), 128'({4'(nfill), ref_mem[wa]}));
                nfill++;
            end
            if (FillDone) begin
                ndone++;
                if (!(FillValid && FillIndex == 4'(LW - 1))) done_ok = 1'b0;
            end
            if (FillError) begin
                nerr++;
                err_cyc = cyc;
            end
            if (CReady) begin
                rdy_cyc = cyc;
                break;
            end
        end
        if (wr) begin
            check("wr_fills", 128'({nfill, nerr, ndone}), 128'({32'd0, 32'd0, 32'd0}));
            check("wr_ready_cyc", 128'(rdy_cyc), 128'(GAP + 1));
        end else if (dead_mem) begin
            check("to_fills", 128'({nfill, ndone}), 128'({32'd0, 32'd0}));
            check("to_err", 128'({nerr, err_cyc}), 128'({32'd1, 32'(TMO)}));
            check("to_ready_cyc", 128'(rdy_cyc), 128'(TMO + GAP));
        end else begin
            check("rd_count", 128'({nfill, nerr, ndone}), 128'({32'(LW), 32'd0, 32'd1}));
            check("rd_done_last", 128'(done_ok), 128'(1));
            check("rd_first_cyc", 128'(fill0_cyc), 128'(mem_wait + 1));
            check("rd_ready_cyc", 128'(rdy_cyc), 128'(mem_wait + LW + GAP));
        end
    endtask

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [31:0] wd;
        logic [15:0] maddr;
        logic [31:0] w0;
    } vec_t;

    vec_t vecs [8];

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : main
        logic [15:0] om;
        logic [31:0] ow;
        int          n;
        int          n_en;
        int          nf;
        int          first;
        int          second;
        bit          found;

        n_cmp = 0;
        n_bad = 0;
        for (int i = 0; i < 16384; i++) begin
            mem[i]     = 32'(i * 4);
            ref_mem[i] = 32'(i * 4);
        end
        vecs[0] = '{1'b1, 16'h0206, 32'hDEADBEEF, 16'h0204, 32'h0};
        vecs[1] = '{1'b0, 16'h0124, 32'h0,        16'h0100, 32'h00000100};
        vecs[2] = '{1'b1, 16'h0040, 32'hA5A5A5A5, 16'h0040, 32'h0};
        vecs[3] = '{1'b0, 16'h0040, 32'h0,        16'h0040, 32'hA5A5A5A5};
        vecs[4] = '{1'b0, 16'h0207, 32'h0,        16'h0200, 32'h00000200};
        vecs[5] = '{1'b0, 16'hFFFF, 32'h0,        16'hFFC0, 32'h0000FFC0};
        vecs[6] = '{1'b1, 16'h0003, 32'h12345678, 16'h0000, 32'h0};
        vecs[7] = '{1'b0, 16'h003C, 32'h0,        16'h0000, 32'h12345678};

        reset      = 1'b0;
        CReq       = 1'b0;
        CWrite     = 1'b0;
        CAddr      = '0;
        CWriteData = '0;
        dead_mem   = 1'b0;
        mem_wait   = 3;

        repeat (3) @(negedge clock);
        #1;
        check("rst_cready", 128'(CReady), 128'(0));
        check("rst_fill", 128'({FillValid, FillIndex, FillData, FillDone, FillError}), 128'(0));
        check("rst_mbus", 128'({MEnable, MRead, MWrite, MAddress, MWriteData}), 128'(0));

        @(negedge clock);
        reset = 1'b1;
        n     = 0;
        #1;
        while (!CReady && n < 50) begin
            @(negedge clock);
            #1;
            n++;
        end
        check("rst_gap_len", 128'(n), 128'(GAP));

        for (int i = 0; i < 8; i++) begin
            mem_wait = (i % 5) + 2;
            run_req(vecs[i].wr, vecs[i].addr, vecs[i].wd, om, ow);
            check("vec_maddr", 128'(om), 128'(vecs[i].maddr));
            if (!vecs[i].wr) check("vec_word0", 128'(ow), 128'(vecs[i].w0));
        end

        for (int i = 0; i < 20; i++) begin
            mem_wait = $urandom_range(2, 12);
            run_req(1'($urandom_range(0, 1)), 16'($urandom_range(0, 1023)), $urandom, om, ow);
        end

        // Dead memory: MReady never drops after the read issue.
        dead_mem = 1'b1;
        run_req(1'b0, 16'h0500, 32'h0, om, ow);
        dead_mem = 1'b0;

        // Reset mid-burst, then a clean fill of the same line.
        mem_wait = 3;
        send_req(1'b0, 16'h0480, 32'h0);
        found = 1'b0;
        for (int c = 0; c < 100 && !found; c++) begin
            @(negedge clock);
            #1;
            if (FillValid && FillIndex == 4'd5) found = 1'b1;
        end
        check("mid_idx5_seen", 128'(found), 128'(1));
        reset = 1'b0;
        #1;
        check("async_rst_outs", 128'({CReady, FillValid, FillIndex, FillData, FillDone, FillError,
                                       MEnable, MRead, MWrite, MAddress, MWriteData}), 128'(0));
        repeat (2) @(negedge clock);
        reset = 1'b1;
        run_req(1'b0, 16'h04A8, 32'h0, om, ow);
        check("post_rst_maddr", 128'(om), 128'(16'h0480));

        // CReq held across burst and gap: reissued only once idle.
        mem_wait   = 4;
        CReq       = 1'b1;
        CWrite     = 1'b0;
        CAddr      = 16'h0310;
        CWriteData = '0;
        n_en       = 0;
        nf         = 0;
        first      = -1;
        second     = -1;
        for (int c = 0; c < 300; c++) begin
            @(negedge clock);
            #1;
            if (FillValid) nf++;
            if (MEnable) begin
                n_en++;
                if (first < 0) begin
                    first = c;
                end else if (second < 0) begin
                    second = c;
                    CReq   = 1'b0;
                end
            end
            if (second >= 0 && c > second && CReady) break;
        end
        CReq = 1'b0;
        check("hold_issue_count", 128'(n_en), 128'(2));
        check("hold_reissue_gap", 128'(second - first), 128'(mem_wait + LW + GAP + 1));
        check("hold_fill_count", 128'(nf), 128'(2 * LW));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
